// File: rtl/jtkcpu_aluseq.sv
// Multi-cycle sequencer for the KCPU ALU: shift-by-count loops and DIVXB.
// Shifts recirculate the ALU result; divides pulse the divider and wait on busy.
module jtkcpu_aluseq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic        kind,
    input  logic [7:0]  cnt,
    input  logic [15:0] din,
    input  logic [7:0]  cc_in,
    input  logic [15:0] alu_rslt,
    input  logic [15:0] alu_rslt_hi,
    input  logic [7:0]  alu_cc,
    input  logic        div_busy,
    output logic [15:0] opnd,
    output logic        div_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] rslt,
    output logic [15:0] rslt_hi,
    output logic [7:0]  cc_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        DIV_GO   = 2'd2,
        DIV_WAIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] opnd_q, opnd_d;
    logic [15:0] rslt_q, rslt_d;
    logic [15:0] rslt_hi_q, rslt_hi_d;
    logic [7:0]  cc_q, cc_d;
    logic [7:0]  count_q, count_d;
    logic        div_en_q, div_en_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        seen_q, seen_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            opnd_q    <= 16'd0;
            rslt_q    <= 16'd0;
            rslt_hi_q <= 16'd0;
            cc_q      <= 8'd0;
            count_q   <= 8'd0;
            div_en_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            seen_q    <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            rslt_q    <= rslt_d;
            rslt_hi_q <= rslt_hi_d;
            cc_q      <= cc_d;
            count_q   <= count_d;
            div_en_q  <= div_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            seen_q    <= seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = kind ? DIV_GO : SHIFT;
            SHIFT:    if (count_q == 8'd0) state_d = IDLE;
            DIV_GO:   state_d = DIV_WAIT;
            DIV_WAIT: if (seen_q && !div_busy) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        opnd_d    = opnd_q;
        rslt_d    = rslt_q;
        rslt_hi_d = rslt_hi_q;
        cc_d      = cc_q;
        count_d   = count_q;
        div_en_d  = div_en_q;
        seen_d    = seen_q;
        done_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d   = din;
                    cc_d     = cc_in;
                    count_d  = cnt;
                    div_en_d = kind;
                end
            end
            SHIFT: begin
                if (count_q == 8'd0) begin
                    rslt_d    = opnd_q;
                    rslt_hi_d = 16'd0;
                    done_d    = 1'b1;
                end else begin
                    opnd_d  = alu_rslt;
                    cc_d    = alu_cc;
                    count_d = count_q - 8'd1;
                end
            end
            DIV_GO: begin
                div_en_d = 1'b0;
                seen_d   = 1'b0;
            end
            DIV_WAIT: begin
                // divider raises busy a cycle late, so skip the first edge
                if (!seen_q) begin
                    seen_d = 1'b1;
                end else if (!div_busy) begin
                    rslt_d    = alu_rslt;
                    rslt_hi_d = alu_rslt_hi;
                    cc_d      = alu_cc;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign opnd    = opnd_q;
    assign div_en  = div_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rslt    = rslt_q;
    assign rslt_hi = rslt_hi_q;
    assign cc_out  = cc_q;

endmodule

// File: doc/jtkcpu_aluseq.md
# jtkcpu_aluseq

Multi-cycle sequencer for the KCPU ALU. It runs the two ALU operations that take more than one step: shift-by-count (ASRD/ASLD/LSRD/RORD/ROLD with a count operand) and the DIVXB divide. For shifts it feeds the ALU result back into the ALU once per step. For divides it pulses the divider start and waits for its busy flag to clear. Sits between the microcode control unit and the ALU; the control unit holds its own sequencing while `busy` is high.

## Interface
Parameters: none.

Clock and reset are fixed: one clock; reset is asynchronous and active-high.

Ports:
- clk — in — 1 — system clock.
- rst — in — 1 — asynchronous, active-high reset.
- cen — in — 1 — clock enable; state and registered outputs advance only on clk edges with cen=1.
- start — in — 1 — request, sampled in IDLE only.
- kind — in — 1 — 0 = shift-by-count, 1 = divide; sampled with start.
- cnt — in — 8 — shift count (0–255); sampled with start.
- din — in — 16 — initial operand; sampled with start.
- cc_in — in — 8 — current CC; sampled with start.
- alu_rslt — in — 16 — ALU result for the current opnd.
- alu_rslt_hi — in — 16 — ALU high result (remainder for divide).
- alu_cc — in — 8 — ALU CC output for the current step.
- div_busy — in — 1 — divider busy flag from the ALU.
- opnd — out — 16 — operand driven to ALU opnd0.
- div_en — out — 1 — divider start pulse.
- busy — out — 1 — high whenever state ≠ IDLE.
- done — out — 1 — one-cen-cycle completion pulse.
- rslt — out — 16 — final result.
- rslt_hi — out — 16 — final high result.
- cc_out — out — 8 — final CC.

## Operation
- States: IDLE, SHIFT, DIV_GO, DIV_WAIT. Every output is registered.
- Reset values: state=IDLE; opnd, rslt, rslt_hi = 0; cc_out = 0; div_en, done, busy = 0; count = 0; seen = 0.
- `done` clears on the next cen edge after it is set, unless it is set again on that same edge.
- **IDLE**, on start=1:
  - opnd←din, cc_out←cc_in, count←cnt.
  - kind=0: go to SHIFT.
  - kind=1: go to DIV_GO and set div_en←1.
- **SHIFT**, one step per cen edge:
  - count=0: rslt←opnd, rslt_hi←0, done←1, go to IDLE.
  - count≠0: opnd←alu_rslt, cc_out←alu_cc, count←count−1.
  - cnt=0 therefore returns din unchanged with cc_in unchanged.
  - CC after a non-zero count is the alu_cc of the last step.
- **DIV_GO**: div_en←0, seen←0, go to DIV_WAIT. div_en is high for exactly one cen cycle.
- **DIV_WAIT**:
  - First edge: seen←1 and div_busy is ignored. This covers the divider's one-cycle latency in raising busy.
  - Later edges, with div_busy=0: rslt←alu_rslt, rslt_hi←alu_rslt_hi, cc_out←alu_cc, done←1, go to IDLE.
  - No timeout.
- start outside IDLE is ignored; no queueing.
- start on the same edge that sets done (state returning to IDLE) is ignored; it is accepted from the following edge.
- rst mid-operation: immediate return to reset values, with no done pulse. div_en drops asynchronously.
- Arithmetic: count is an 8-bit down-counter and never wraps, since it stops at 0. opnd, rslt and rslt_hi are 16-bit with no width conversion.

## Timing
- All edges counted here are cen-qualified; with cen=0 every register holds, including the done and div_en pulses.
- Shift by n: start sampled at edge E0. busy is high from E0 through E0+n+1. done is high for one cycle after edge E0+n+1.
  - Latency is n+2 cen cycles from start to done. n=0 gives done after E0+1.
- Divide: div_en is high between E0 and E0+1. seen is set at E0+2. done follows the first edge ≥ E0+3 with div_busy=0.
  - If div_busy never rises, done follows E0+3.
- opnd is stable for a full cen cycle before the ALU result is sampled. The ALU is combinational on opnd.

## Test plan
- **Shift by 3:** ALU modelled as ASR16. din=0x8010, cnt=3, kind=0 → opnd sequence 0x8010, 0xC008, 0xE004, 0xF002; rslt=0xF002; done 5 cen cycles after start; busy=0 afterwards.
- **Shift by 0:** din=0x1234, cc_in=0x05, cnt=0 → rslt=0x1234, cc_out=0x05, done 2 cycles after start; no opnd change.
- **Divide:** din=0x0064, div_busy high for 16 cycles from E0+2, alu_rslt=0x0014, alu_rslt_hi=0x0000 → div_en exactly one cycle; done one cycle after div_busy falls; rslt=0x0014.
- **Start while busy:** start and kind=1 pulsed during a shift by 5 → no div_en, shift result unaffected, exactly one done.
- **Reset mid-operation:** rst asserted asynchronously during SHIFT with count=2 → all outputs 0 immediately, no done. A new start after release works normally.
- **cen gating:** cen toggled 1-0-1-0 during shift by 2 → the same opnd and rslt sequence as with cen=1, stretched 2×; done lasts exactly one cen-high cycle.
